// File: rtl/mbist_pkg.sv
// Shared definitions for the MBIST address generator.
//   addr_gen_state_e : sweep control states (idle, running, one-cycle done)
//   ADDR_W_DEF       : default address width
//   STEP_W_DEF       : default stride width
package mbist_pkg;

   typedef enum logic [1:0] {AG_IDLE, AG_RUN, AG_DONE} addr_gen_state_e;

   localparam int unsigned ADDR_W_DEF = 10;
   localparam int unsigned STEP_W_DEF = 4;

endpackage

// File: rtl/mbist_addr_gen_if.sv
// Bundle between the MBIST controller FSM and the address generator.
//   controller -> generator : start, abort, cen, u_d, wrap_mode, lo, hi, step
//   generator -> controller : addr, busy, last, done, cout, err
// master = controller side, slave = address generator side.
interface mbist_addr_gen_if
   import mbist_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned STEP_W = STEP_W_DEF
);

   logic              start;
   logic              abort;
   logic              cen;
   logic              u_d;
   logic              wrap_mode;
   logic [ADDR_W-1:0] lo;
   logic [ADDR_W-1:0] hi;
   logic [STEP_W-1:0] step;
   logic [ADDR_W-1:0] addr;
   logic              busy;
   logic              last;
   logic              done;
   logic              cout;
   logic              err;

   modport master (
      output start, abort, cen, u_d, wrap_mode, lo, hi, step,
      input  addr, busy, last, done, cout, err
   );

   modport slave (
      input  start, abort, cen, u_d, wrap_mode, lo, hi, step,
      output addr, busy, last, done, cout, err
   );

endinterface

// File: rtl/mbist_addr_gen.sv
// MBIST address generator: sweeps addr through the window [lo, hi] with a
// programmable stride, up or down, once or looping until abort.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of mbist_addr_gen_if (start/abort/cen handshake,
//           window/stride config in; addr, busy, last, done, cout, err out)
module mbist_addr_gen
   import mbist_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned STEP_W = STEP_W_DEF
) (
   input logic              clk,
   input logic              rst_n,
   mbist_addr_gen_if.slave  bus
);

   localparam int unsigned SUM_W = ADDR_W + 1;

   addr_gen_state_e   state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic              cout_q, cout_d;
   logic              load;

   // configuration latched at start, frozen for the whole sweep
   logic              u_d_q;
   logic              wrap_q;
   logic [ADDR_W-1:0] lo_q;
   logic [ADDR_W-1:0] hi_q;
   logic [STEP_W-1:0] step_q;

   logic [ADDR_W-1:0] step_ext;
   logic [SUM_W-1:0]  sum_up;
   logic              terminal;
   logic              illegal;

   // Up: compare in ADDR_W+1 bits so addr+step cannot wrap past the top.
   // Down: addr >= lo always holds in RUN, so addr-lo never underflows and
   // addr-step is only formed when it stays at or above lo.
   always_comb begin
      step_ext = ADDR_W'(step_q);
      sum_up   = SUM_W'(addr_q) + SUM_W'(step_q);
      terminal = u_d_q ? (sum_up > SUM_W'(hi_q))
                       : ((addr_q - lo_q) < step_ext);
      illegal  = (bus.lo > bus.hi) || (bus.step == '0);
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      err_d   = err_q;
      done_d  = 1'b0;
      cout_d  = 1'b0;
      load    = 1'b0;
      case (state_q)
         AG_IDLE: begin
            if (bus.start && !bus.abort) begin
               if (illegal) begin
                  err_d = 1'b1;
               end else begin
                  load    = 1'b1;
                  err_d   = 1'b0;
                  addr_d  = bus.u_d ? bus.lo : bus.hi;
                  state_d = AG_RUN;
               end
            end
         end
         AG_RUN: begin
            if (bus.abort) begin
               state_d = AG_IDLE;
            end else if (bus.cen) begin
               if (!terminal) begin
                  addr_d = u_d_q ? (addr_q + step_ext) : (addr_q - step_ext);
               end else if (wrap_q) begin
                  addr_d = u_d_q ? lo_q : hi_q;
                  cout_d = 1'b1;
               end else begin
                  state_d = AG_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         AG_DONE: state_d = AG_IDLE;
         default: state_d = AG_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= AG_IDLE;
         addr_q  <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
         u_d_q   <= 1'b0;
         wrap_q  <= 1'b0;
         lo_q    <= '0;
         hi_q    <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
         done_q  <= done_d;
         cout_q  <= cout_d;
         if (load) begin
            u_d_q  <= bus.u_d;
            wrap_q <= bus.wrap_mode;
            lo_q   <= bus.lo;
            hi_q   <= bus.hi;
            step_q <= bus.step;
         end
      end
   end

   assign bus.addr = addr_q;
   assign bus.busy = (state_q == AG_RUN);
   assign bus.last = (state_q == AG_RUN) && terminal;
   assign bus.done = done_q;
   assign bus.cout = cout_q;
   assign bus.err  = err_q;

endmodule

// File: doc/mbist_addr_gen.md
Name: mbist_addr_gen

Overview:
Parametrised MBIST address generator; next generation of the plain up/down counter.
Adds a programmable address window [lo, hi], a programmable stride, single-pass or looping mode, and a start/busy/done handshake with abort.
Sits between the MBIST controller FSM, which issues start/abort/cen, and the memory address port.
Drives one march element's address sweep per start.

Parameters:
ADDR_W, 10, address width in bits
STEP_W, 4, stride width in bits

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous, active-low reset
start  input  1  begin a sweep; honoured only in IDLE
abort  input  1  terminate the sweep; honoured in RUN
cen  input  1  advance enable; one step per cycle while high in RUN
u_d  input  1  direction: 1 = up (lo to hi), 0 = down (hi to lo); sampled at start
wrap_mode  input  1  0 = single pass, 1 = loop until abort; sampled at start
lo  input  ADDR_W  lower bound, inclusive; sampled at start
hi  input  ADDR_W  upper bound, inclusive; sampled at start
step  input  STEP_W  stride; sampled at start
addr  output  ADDR_W  current address
busy  output  1  high in RUN
last  output  1  combinational; high in RUN when the next advance is terminal
done  output  1  one-cycle pulse when a single pass completes
cout  output  1  one-cycle pulse on each loop reload (wrap_mode=1)
err  output  1  configuration error; sticky until the next start

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - addr=0, busy=0, done=0, cout=0, err=0.
  - Overrides everything, including mid-sweep; there is no done pulse on reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and abort=0:
    - Config is illegal if lo>hi or step==0. Then err<=1 and state stays IDLE.
    - Otherwise:
      - Latch u_d, wrap_mode, lo, hi and step.
      - err<=0.
      - addr<=(u_d ? lo : hi), the start bound.
      - state<=RUN.
  - start=1 with abort=1 in the same cycle: start is ignored.
  - Latency: start at edge N gives busy=1 and addr=start bound after edge N.
- RUN, priority abort > cen:
  - abort=1: state<=IDLE and busy<=0. addr holds its value. No done, no cout.
  - cen=0: addr holds; no pulses.
  - cen=1 and not terminal: addr<=addr+step (up) or addr-step (down).
  - cen=1 and terminal, wrap_mode=0: addr holds; state<=DONE.
  - cen=1 and terminal, wrap_mode=1: addr<=start bound; cout=1 for exactly one cycle; stay in RUN.
  - start in RUN is ignored; latched config cannot change mid-sweep.
- Terminal condition, with no wrap-around through 0 or 2^ADDR_W:
  - Up: addr+step > hi. Evaluate in ADDR_W+1 bits so the sum cannot overflow.
  - Down: (addr-lo) < step. Never compute addr-step below zero.
- last equals the terminal condition while in RUN; last=0 outside RUN.
- DONE: lasts exactly one cycle. done=1, busy=0, then state<=IDLE. addr keeps the last visited address.
- done, cout and err are registered outputs.
- Every visited address is in [lo, hi]. The final address need not equal the far bound when the span is not a multiple of step.
- lo==hi is legal: the sweep is one address and last=1 immediately.

Decomposition:
- Package mbist_pkg holds:
  - typedef enum logic [1:0] addr_gen_state_e {AG_IDLE, AG_RUN, AG_DONE};
  - localparam defaults ADDR_W_DEF=10 and STEP_W_DEF=4.
- Single module; no sub-module. The terminal/next-address logic stays an inline combinational block.

Test Plan:
- Up, single pass: lo=2, hi=9, step=3, wrap_mode=0, start, then cen held high -> addr 2,5,8.
  - last=1 at 8.
  - Next cen gives a done pulse for 1 cycle, busy falls, addr stays 8.
- Down, single pass, same config with u_d=0 -> addr 9,6,3, then done.
  - addr never goes below lo.
  - No underflow at lo=0, hi=3, step=4: addr 3, then done.
- Looping, full range: ADDR_W=10, lo=0, hi=1023, step=1, wrap_mode=1, up -> 1022, 1023, 0.
  - cout pulses once when 1023 goes to 0.
  - busy stays 1.
  - abort then gives IDLE with no done.
- Overflow boundary: lo=1020, hi=1023, step=4, up -> addr 1020 and last=1 immediately.
  - Next cen gives done.
  - addr is never 0 (the ADDR_W+1-bit compare works).
- Illegal config: lo=5, hi=4, start -> err=1, busy=0, state IDLE.
  - Then a legal start -> err=0 and busy=1.
  - step=0 also gives err=1.
- Hold and reset:
  - cen=0 for 5 cycles mid-run -> addr constant, no pulses.
  - start during RUN is ignored.
  - rst_n=0 mid-run -> next cycle addr=0, busy=0, done=0, cout=0, err=0.
